// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter sequencing safe writes (setup / enable window / hold) into a shared D-latch bank.
// Define LATCH_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module latch_bank_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int EN_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] d,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic                  busy,
    output logic [WIDTH-1:0]      latch_d,
    output logic                  latch_en,
    output logic                  latch_rst_n
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, CLOSE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rst_q;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [IW-1:0] idx;

`ifndef LATCH_ARB_FIXED_PRIO_EN
    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
`endif

    // First requesting index, scanning upward from the search origin
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
            idx = IW'(i);
`else
            idx = IW'((int'(ptr) + i) % NREQ);
`endif
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // Bank reset is held one extra cycle past the release of reset
        rst_q       <= reset;
        latch_rst_n <= !(reset || rst_q);
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            latch_d  <= '0;
            latch_en <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
            ptr      <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld && latch_rst_n) begin
                        state   <= SETUP;
                        gnt     <= NREQ'(1) << pick;
                        latch_d <= d[int'(pick)*WIDTH +: WIDTH];
                        busy    <= 1'b1;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                        win     <= pick;
`endif
                    end
                end
                SETUP: begin
                    state    <= OPEN;
                    latch_en <= 1'b1;
                    cnt      <= CW'(EN_CYCLES - 1);
                end
                OPEN: begin
                    if (cnt == '0) begin
                        state    <= CLOSE;
                        latch_en <= 1'b0;
                        ack      <= gnt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CLOSE: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
`ifndef LATCH_ARB_FIXED_PRIO_EN
                    ptr   <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Randomized bench for latch_bank_arbiter: two instances (EN_CYCLES=2 and 1) against a transaction-level model.
module tb_latch_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] d = '0;

    logic [NREQ-1:0]  gnt [2];
    logic [NREQ-1:0]  ack [2];
    logic             busy [2];
    logic [WIDTH-1:0] ld [2];
    logic             len [2];
    logic             lrn [2];

    latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .EN_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .req(req), .d(d), .gnt(gnt[0]), .ack(ack[0]),
        .busy(busy[0]), .latch_d(ld[0]), .latch_en(len[0]), .latch_rst_n(lrn[0]));
    latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .EN_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req), .d(d), .gnt(gnt[1]), .ack(ack[1]),
        .busy(busy[1]), .latch_d(ld[1]), .latch_en(len[1]), .latch_rst_n(lrn[1]));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: position within a transaction (0 = idle, 1 = setup, 2..EN+1 = open, EN+2 = close)
    int               m_pos [2];
    int               m_win [2];
    int               m_ptr [2];
    logic [WIDTH-1:0] m_data [2];
    logic [WIDTH-1:0] m_bank [2];
    logic [WIDTH-1:0] bank [2];
    logic             m_r1 = 1'b1;
    logic             m_r2 = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int en_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int pick_winner(input logic [NREQ-1:0] r, input int p);
        logic [NREQ-1:0] t;
        int idx;
        for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_ARB_FIXED_PRIO_EN
            idx = i;
`else
            idx = (p + i) % NREQ;
`endif
            t = r >> idx;
            if (t[0]) return idx;
        end
        return 0;
    endfunction

    task automatic model_update();
        logic ok;
        ok = !(m_r1 || m_r2);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pos[k]  = 0;
                m_ptr[k]  = 0;
                m_data[k] = '0;
            end else if (m_pos[k] == 0) begin
                if (ok && req != '0) begin
                    m_win[k]  = pick_winner(req, m_ptr[k]);
                    m_data[k] = WIDTH'(d >> (m_win[k] * WIDTH));
                    m_pos[k]  = 1;
                end
            end else if (m_pos[k] == en_of(k) + 2) begin
                m_pos[k] = 0;
                m_ptr[k] = (m_win[k] + 1) % NREQ;
            end else begin
                m_pos[k]++;
            end
        end
        m_r2 = m_r1;
        m_r1 = reset;
        for (int k = 0; k < 2; k++) begin
            if (m_r1 || m_r2) m_bank[k] = '0;
            else if (m_pos[k] >= 2 && m_pos[k] <= en_of(k) + 1) m_bank[k] = m_data[k];
        end
    endtask

    // One clock: advance the model at the edge, compare every output mid-cycle
    task automatic step();
        logic [NREQ-1:0] eg;
        int p;
        int en;
        @(posedge clk);
        model_update();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            p  = m_pos[k];
            en = en_of(k);
            eg = (p != 0) ? (NREQ'(1) << m_win[k]) : '0;
            if (!lrn[k]) bank[k] = '0;
            else if (len[k]) bank[k] = ld[k];
            check_val($sformatf("gnt%0d", k), 32'(gnt[k]), 32'(eg));
            check_val($sformatf("ack%0d", k), 32'(ack[k]), (p == en + 2) ? 32'(eg) : 32'd0);
            check_val($sformatf("busy%0d", k), 32'(busy[k]), 32'(p != 0));
            check_val($sformatf("latch_en%0d", k), 32'(len[k]), 32'(p >= 2 && p <= en + 1));
            check_val($sformatf("latch_d%0d", k), 32'(ld[k]), 32'(m_data[k]));
            check_val($sformatf("latch_rst_n%0d", k), 32'(lrn[k]), 32'(!(m_r1 || m_r2)));
            check_val($sformatf("result%0d", k), 32'(bank[k]), 32'(m_bank[k]));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        repeat (2) step();
    endtask

    int waited;
    logic [NREQ-1:0] exp_ack;

    initial begin
        // Reset: 3 cycles high, bank reset low one extra cycle
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_val("rst_tail_low", 32'(lrn[0]), 32'd0);
        step();
        check_val("rst_tail_high", 32'(lrn[0]), 32'd1);
        check_val("rst_result", 32'(bank[0]), 32'h00);

        // Single write from requester 2
        d = '0;
        d[2*WIDTH +: WIDTH] = 8'hA5;
        req = 4'b0100;
        step();
        req = '0;
        repeat (8) step();
        check_val("single_result0", 32'(bank[0]), 32'hA5);
        check_val("single_result1", 32'(bank[1]), 32'hA5);

        // Round-robin with all requesters pending
        do_reset(2);
        d = 32'h44_33_22_11;
        req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            waited = 0;
            do begin
                step();
                waited++;
            end while (ack[0] == '0 && waited < 20);
            check_val("rr_ack_seen", 32'(ack[0] != '0), 32'd1);
`ifdef LATCH_ARB_FIXED_PRIO_EN
            exp_ack = 4'b0001;
`else
            exp_ack = NREQ'(1) << (t % NREQ);
`endif
            check_val("rr_order", 32'(ack[0]), 32'(exp_ack));
            if (t > 0) check_val("rr_gap", 32'(waited), 32'd5);
        end
        req = '0;
        repeat (6) step();

        // Data change and request drop mid-transaction
        do_reset(1);
        d = '0;
        d[1*WIDTH +: WIDTH] = 8'h3C;
        req = 4'b0010;
        repeat (2) step();
        d[1*WIDTH +: WIDTH] = 8'hFF;
        req = '0;
        repeat (6) step();
        check_val("hold_result0", 32'(bank[0]), 32'h3C);
        check_val("hold_result1", 32'(bank[1]), 32'h3C);

        // Reset during the enable window
        d = 32'h00_00_00_77;
        req = 4'b0001;
        repeat (3) step();
        reset = 1'b1;
        step();
        req = '0;
        reset = 1'b0;
        step();
        check_val("rst_mid_result", 32'(bank[0]), 32'h00);
        repeat (3) step();

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) req = NREQ'($urandom);
            d = $urandom;
            reset = ($urandom_range(0, 59) == 0);
            step();
        end
        reset = 1'b0;
        req = '0;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
